// File: rtl/frame_cmd_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package  : frame_cmd_scheduler_pkg
// Brief    : Shared types and VGA frame constants for the command scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package frame_cmd_scheduler_pkg;

  localparam int c_vga_visible_rows = 480;
  localparam int c_vga_total_rows   = 525;
  localparam int c_row_w            = 10;
  localparam int c_cmd_w_default    = 24;
  localparam int c_last_row_default = c_vga_total_rows - 1;

  typedef enum logic [1:0] {
    WAIT_BLANK  = 2'd0,
    DRAIN       = 2'd1,
    COMMIT      = 2'd2,
    WAIT_ACTIVE = 2'd3
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_cmd_scheduler_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : frame_cmd_scheduler_cmd_fifo
// Brief    : Synchronous FIFO with registered storage, level output, no bypass.
// Revision : 1.0 - initial release
// ============================================================================
module frame_cmd_scheduler_cmd_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_full_level = (c_aw + 1)'(DEPTH);

  logic [W-1:0]    r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign full   = (r_count == c_full_level);
  assign empty  = (r_count == '0);
  assign level  = r_count;
  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : frame_cmd_scheduler
// Brief    : Queues host commands during active video, drains them in vertical
//            blanking and pulses commit once per frame before the next frame.
// Options  : FRAME_CMD_STATS_EN adds cmd_per_frame and late_flag outputs.
// Revision : 1.0 - initial release
// ============================================================================
module frame_cmd_scheduler
  import frame_cmd_scheduler_pkg::*;
#(
  parameter int CMD_W    = c_cmd_w_default,
  parameter int DEPTH    = 8,
  parameter int LAST_ROW = c_last_row_default,
  parameter int FRAME_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     screen_inactive,
  input  logic [c_row_w-1:0]       row_counter,
  input  logic                     cmd_in_valid,
  input  logic [CMD_W-1:0]         cmd_in_data,
  output logic                     cmd_in_ready,
  output logic                     cmd_out_valid,
  output logic [CMD_W-1:0]         cmd_out_data,
  input  logic                     cmd_out_ready,
  output logic                     commit,
  output logic [FRAME_W-1:0]       frame_cnt,
`ifdef FRAME_CMD_STATS_EN
  output logic [7:0]               cmd_per_frame,
  output logic                     late_flag,
`endif
  output logic [$clog2(DEPTH):0]   fifo_level
);

  sched_state_t       r_state;
  sched_state_t       w_next_state;
  logic               w_at_last_row;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [FRAME_W-1:0] r_frame_cnt;

  assign w_at_last_row = (row_counter == c_row_w'(LAST_ROW));

  assign cmd_in_ready  = rst_n && !w_full;
  assign w_push        = cmd_in_valid && cmd_in_ready;
  // Gating on the last row keeps a handshake from racing the DRAIN->COMMIT exit.
  assign cmd_out_valid = (r_state == DRAIN) && !w_empty && !w_at_last_row;
  assign w_pop         = cmd_out_valid && cmd_out_ready;
  assign commit        = (r_state == COMMIT);
  assign frame_cnt     = r_frame_cnt;

  frame_cmd_scheduler_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (cmd_in_data),
    .pop       (w_pop),
    .head      (cmd_out_data),
    .full      (w_full),
    .empty     (w_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_BLANK;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WAIT_BLANK:  if (screen_inactive && !w_at_last_row) w_next_state = DRAIN;
      DRAIN:       if (w_at_last_row) w_next_state = COMMIT;
      COMMIT:      w_next_state = WAIT_ACTIVE;
      WAIT_ACTIVE: if (!screen_inactive) w_next_state = WAIT_BLANK;
      default:     w_next_state = WAIT_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (commit) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

`ifdef FRAME_CMD_STATS_EN
  logic [7:0] r_hs_cnt;
  logic [7:0] r_cmd_per_frame;
  logic       r_late_flag;

  assign cmd_per_frame = r_cmd_per_frame;
  assign late_flag     = r_late_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_cnt        <= '0;
      r_cmd_per_frame <= '0;
      r_late_flag     <= 1'b0;
    end else if (commit) begin
      r_hs_cnt        <= '0;
      r_cmd_per_frame <= r_hs_cnt;
      r_late_flag     <= !w_empty;
    end else if (w_pop && (r_hs_cnt != 8'hFF)) begin
      r_hs_cnt <= r_hs_cnt + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire
